// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC at a one-cycle-latency instruction memory and
// buffers returned words with their PCs in a small queue presented to decode.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_req,
    input  logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] curr_instr,
    output logic [ADDR_W-1:0]  curr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               pop;
    logic               push;
    logic [CNT_W:0]     credit;

    assign instr_addr  = pc;
    assign instr_valid = !rst && (count != '0);
    assign curr_instr  = instr_mem[head];
    assign curr_pc     = pc_mem[head];
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !redirect;

    // Slots committed once this cycle settles; a pop frees its slot for a same-cycle request.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign instr_req = !rst && !redirect && (credit < (CNT_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect) begin
            // Flush: queued entries and the word returning now are dropped.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            head     <= tail;
            count    <= '0;
        end else begin
            inflight <= instr_req;
            if (instr_req) begin
                req_pc <= pc;
                pc     <= pc + 1'b1;
            end
            if (push) begin
                pc_mem[tail]    <= req_pc;
                instr_mem[tail] <= instr;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two configurations share directed and random stimulus and are
// compared every cycle against a queue-based model, plus literal sequence checks.
module tb_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b1;
    logic        ready    = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rpc      = '0;

    logic [7:0]  addr0, cpc0;
    logic        req0, valid0;
    logic [15:0] instr0 = '0;
    logic [15:0] cins0;
    logic [9:0]  addr1, cpc1;
    logic        req1, valid1;
    logic [31:0] instr1 = '0;
    logic [31:0] cins1;

    fetch_stage u0 (
        .clk(clk), .rst(rst), .instr_addr(addr0), .instr_req(req0), .instr(instr0),
        .curr_instr(cins0), .curr_pc(cpc0), .instr_valid(valid0), .instr_ready(ready),
        .redirect(redirect), .redirect_pc(rpc[7:0])
    );

    fetch_stage #(.ADDR_W(10), .INSTR_W(32), .DEPTH(4), .RESET_PC(10'h000)) u1 (
        .clk(clk), .rst(rst), .instr_addr(addr1), .instr_req(req1), .instr(instr1),
        .curr_instr(cins1), .curr_pc(cpc1), .instr_valid(valid1), .instr_ready(ready),
        .redirect(redirect), .redirect_pc(rpc[9:0])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dp(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] amask(int i);
        return (i == 0) ? 32'h0FF : 32'h3FF;
    endfunction

    function automatic logic [31:0] word(int i, logic [31:0] a);
        return (i == 0) ? a : (32'hA500_0000 | a);
    endfunction

    // Model: queue of {pc, instr}, one outstanding request, and the fetch PC.
    logic [63:0] mq [2][$];
    logic [31:0] mpc [2];
    logic [31:0] ipc [2];
    bit          infl [2];
    bit          minit [2];
    bit          fresh [2];
    bit          e_req [2];
    bit          e_pop [2];
    logic [31:0] s_addr [2];
    logic        s_req [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            minit[i] = 1'b0;
            fresh[i] = 1'b0;
            s_req[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] d_addr [2];
        logic [31:0] d_cpc  [2];
        logic [31:0] d_cins [2];
        logic        d_req  [2];
        logic        d_val  [2];
        int          sz;
        bit          ev;
        d_addr[0] = 32'(addr0);  d_addr[1] = 32'(addr1);
        d_cpc[0]  = 32'(cpc0);   d_cpc[1]  = 32'(cpc1);
        d_cins[0] = 32'(cins0);  d_cins[1] = cins1;
        d_req[0]  = req0;        d_req[1]  = req1;
        d_val[0]  = valid0;      d_val[1]  = valid1;
        for (int i = 0; i < 2; i++) begin
            s_req[i]  = d_req[i];
            s_addr[i] = d_addr[i];
            if (minit[i]) begin
                sz       = mq[i].size();
                ev       = !rst && (sz > 0);
                e_pop[i] = ev && ready;
                e_req[i] = !rst && !redirect && (sz + int'(infl[i]) - int'(e_pop[i]) < dp(i));
                chk($sformatf("u%0d instr_valid", i), 32'(d_val[i]), 32'(ev));
                chk($sformatf("u%0d instr_req", i), 32'(d_req[i]), 32'(e_req[i]));
                if (!rst) chk($sformatf("u%0d instr_addr", i), d_addr[i], mpc[i]);
                if (ev) begin
                    chk($sformatf("u%0d curr_pc", i), d_cpc[i], mq[i][0][63:32]);
                    chk($sformatf("u%0d curr_instr", i), d_cins[i], mq[i][0][31:0]);
                end else if (fresh[i] && !rst) begin
                    chk($sformatf("u%0d curr_pc cleared", i), d_cpc[i], 32'h0);
                    chk($sformatf("u%0d curr_instr cleared", i), d_cins[i], 32'h0);
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                infl[i]  = 1'b0;
                mpc[i]   = '0;
                ipc[i]   = '0;
                minit[i] = 1'b1;
                fresh[i] = 1'b1;
            end else if (minit[i]) begin
                if (redirect) begin
                    mq[i].delete();
                    infl[i] = 1'b0;
                    mpc[i]  = rpc & amask(i);
                end else begin
                    if (e_pop[i]) void'(mq[i].pop_front());
                    if (infl[i]) begin
                        mq[i].push_back({ipc[i], word(i, ipc[i])});
                        fresh[i] = 1'b0;
                    end
                    infl[i] = e_req[i];
                    if (e_req[i]) begin
                        ipc[i] = mpc[i];
                        mpc[i] = (mpc[i] + 1) & amask(i);
                    end
                end
            end
        end
    end

    // Memory: word for a request is on the bus during the following cycle, junk otherwise.
    always @(posedge clk) begin
        #1;
        instr0 = s_req[0] ? 16'(word(0, s_addr[0])) : 16'($urandom);
        instr1 = s_req[1] ? word(1, s_addr[1]) : $urandom;
    end

    task automatic apply(bit r, bit rdy, bit rd, logic [31:0] p);
        @(posedge clk);
        #1;
        rst      = r;
        ready    = rdy;
        redirect = rd;
        rpc      = p;
        @(negedge clk);
    endtask

    initial begin
        // Reset, then straight streaming
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            chk("rst valid", 32'(valid0), 32'h0);
            chk("rst req", 32'(req0), 32'h0);
        end
        for (int c = 0; c < 22; c++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0);
            if (c == 0) begin
                chk("cycle0 req", 32'(req0), 32'h1);
                chk("cycle0 addr", 32'(addr0), 32'h0);
                chk("cycle0 valid", 32'(valid0), 32'h0);
            end
            if (c >= 2) begin
                chk("stream valid", 32'(valid0), 32'h1);
                chk("stream pc", 32'(cpc0), 32'(c - 2));
                chk("stream instr", 32'(cins0), 32'(c - 2));
            end
        end

        // Stall from cycle 5 for 6 cycles
        repeat (2) apply(1'b1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 18; c++) begin
            apply(1'b0, !(c >= 5 && c <= 10), 1'b0, 32'h0);
            if (c == 10) begin
                chk("stall req", 32'(req0), 32'h0);
                chk("stall valid", 32'(valid0), 32'h1);
                chk("stall head", 32'(cpc0), 32'h3);
                chk("stall req deep", 32'(req1), 32'h0);
            end
            if (c == 11) chk("release req", 32'(req0), 32'h1);
            if (c >= 11) chk("release pc", 32'(cpc0), 32'(c - 8));
        end

        // Redirect to 0x40 at cycle 10
        repeat (2) apply(1'b1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 16; c++) begin
            apply(1'b0, 1'b1, c == 10, 32'h40);
            if (c == 10) chk("redirect-cycle pc", 32'(cpc0), 32'h8);
            if (c == 11 || c == 12) chk("redirect bubble", 32'(valid0), 32'h0);
            if (c >= 13) chk("redirect pc", 32'(cpc0), 32'h40 + 32'(c - 13));
        end

        // Wrap-around from 0xFE
        for (int c = 0; c < 9; c++) begin
            apply(1'b0, 1'b1, c == 0, 32'hFE);
            if (c >= 3 && c <= 6) begin
                chk("wrap pc u0", 32'(cpc0), (32'hFE + 32'(c - 3)) & 32'hFF);
                chk("wrap pc u1", 32'(cpc1), (32'hFE + 32'(c - 3)) & 32'h3FF);
            end
        end

        // Reset mid-stream with full queues
        for (int c = 0; c < 11; c++) apply(1'b0, c < 3, 1'b0, 32'h0);
        chk("full valid u1", 32'(valid1), 32'h1);
        chk("full req u1", 32'(req1), 32'h0);
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        chk("midrst valid", 32'(valid0), 32'h0);
        for (int c = 0; c < 5; c++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0);
            if (c == 0) begin
                chk("after rst valid u0", 32'(valid0), 32'h0);
                chk("after rst valid u1", 32'(valid1), 32'h0);
                chk("after rst addr u1", 32'(addr1), 32'h0);
            end
            if (c >= 2) begin
                chk("restart pc u0", 32'(cpc0), 32'(c - 2));
                chk("restart pc u1", 32'(cpc1), 32'(c - 2));
                chk("restart instr u1", cins1, 32'hA500_0000 | 32'(c - 2));
            end
        end

        // Random readiness, redirects and occasional resets
        for (int c = 0; c < 10000; c++) begin
            apply($urandom_range(0, 999) < 2, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < 4, $urandom);
        end
        repeat (3) apply(1'b0, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
